// File: rtl/dot_pkg.sv
// Shared state encoding and arithmetic helpers for the dot_product_vec engine.
package dot_pkg;

   typedef enum logic [1:0] {eIDLE, eLOAD, eDRAIN, eDONE} state_e;

   localparam int unsigned RS_W  = 128;
   localparam int unsigned RS_DW = 64;

   typedef struct packed {
      logic             sat;
      logic [RS_DW-1:0] data;
   } rs_t;

   function automatic int unsigned acc_w(input int unsigned width,
                                         input int unsigned lanes,
                                         input int unsigned max_len);
      return 2 * width + $clog2(lanes * max_len);
   endfunction

   // Round half up, then clip to a signed width-bit result.
   function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                     input int unsigned            frac,
                                     input int unsigned            width);
      logic signed [RS_W-1:0] one_v;
      logic signed [RS_W-1:0] half_v;
      logic signed [RS_W-1:0] r_v;
      logic signed [RS_W-1:0] max_v;
      logic signed [RS_W-1:0] min_v;
      rs_t                    res;
      one_v  = RS_W'(1);
      half_v = '0;
      if (frac != 0) half_v = one_v <<< (frac - 1);
      r_v    = (acc + half_v) >>> frac;
      max_v  = (one_v <<< (width - 1)) - one_v;
      min_v  = -(one_v <<< (width - 1));
      res.sat  = 1'b0;
      res.data = RS_DW'(r_v);
      if (r_v > max_v) begin
         res.sat  = 1'b1;
         res.data = RS_DW'(max_v);
      end else if (r_v < min_v) begin
         res.sat  = 1'b1;
         res.data = RS_DW'(min_v);
      end
      return res;
   endfunction

endpackage

// File: rtl/dot_lane_tree.sv
// Combinational LANES-wide signed multiply followed by a binary adder tree.
module dot_lane_tree #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LANES = 1
) (
   input  logic        [LANES*WIDTH-1:0]              a_i,
   input  logic        [LANES*WIDTH-1:0]              b_i,
   output logic signed [2*WIDTH+$clog2(LANES)-1:0]    sum_c
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned LV = $clog2(LANES);
   localparam int unsigned SW = PW + LV;

   logic signed [SW-1:0] node [LV+1][LANES];

   // Level 0 holds the full-precision products; each level halves the node count.
   always_comb begin
      for (int unsigned l = 0; l <= LV; l++) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            node[l][i] = '0;
         end
      end
      for (int unsigned i = 0; i < LANES; i++) begin
         node[0][i] = SW'(PW'($signed(a_i[i*WIDTH +: WIDTH])) *
                          PW'($signed(b_i[i*WIDTH +: WIDTH])));
      end
      for (int unsigned l = 0; l < LV; l++) begin
         for (int unsigned i = 0; i < (LANES >> (l + 1)); i++) begin
            node[l+1][i] = node[l][2*i] + node[l][2*i+1];
         end
      end
      sum_c = node[LV][0];
   end

endmodule

// File: rtl/dot_product_vec.sv
// Streaming fixed-point dot product: programmed length, LANES pairs per beat,
// registered product stage, round-half-up and saturating result held until yumi_i.
module dot_product_vec
   import dot_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned FRAC    = 8,
   parameter int unsigned LANES   = 1,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_ni,
   input  logic                          start_i,
   input  logic [$clog2(MAX_LEN+1)-1:0]  len_i,
   input  logic [LANES*WIDTH-1:0]        a_i,
   input  logic [LANES*WIDTH-1:0]        b_i,
   input  logic                          v_i,
   output logic                          ready_o,
   output logic [WIDTH-1:0]              data_o,
   output logic                          sat_o,
   output logic                          v_o,
   input  logic                          yumi_i
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
   localparam int unsigned SUM_W = 2 * WIDTH + $clog2(LANES);
   localparam int unsigned ACC_W = acc_w(WIDTH, LANES, MAX_LEN);

   state_e                  state_q, state_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic signed [SUM_W-1:0] p_q, p_d, sum_c;
   logic                    p_v_q, p_v_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    ready_q, ready_d;
   logic                    v_q, v_d;
   logic                    sat_q, sat_d;
   logic [WIDTH-1:0]        data_q, data_d;
   rs_t                     rs_c;

   dot_lane_tree #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_tree (
      .a_i   (a_i),
      .b_i   (b_i),
      .sum_c (sum_c)
   );

   // Next state, beat pipeline and the result registers that track acc_d.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      p_v_d   = 1'b0;
      acc_d   = acc_q;
      if (p_v_q) acc_d = acc_q + ACC_W'(p_q);
      case (state_q)
         eIDLE: begin
            if (start_i) begin
               acc_d = '0;
               if (len_i == '0) begin
                  state_d = eDONE;
               end else begin
                  state_d = eLOAD;
                  cnt_d   = (32'(len_i) > MAX_LEN) ? LEN_W'(MAX_LEN) : len_i;
               end
            end
         end
         eLOAD: begin
            if (v_i) begin
               p_d   = sum_c;
               p_v_d = 1'b1;
               if (cnt_q == LEN_W'(1)) state_d = eDRAIN;
               else                    cnt_d   = cnt_q - LEN_W'(1);
            end
         end
         eDRAIN:  state_d = eDONE;
         eDONE:   if (yumi_i) state_d = eIDLE;
         default: state_d = eIDLE;
      endcase
      ready_d = (state_d == eLOAD);
      v_d     = (state_d == eDONE);
      rs_c    = round_sat(RS_W'(acc_d), FRAC, WIDTH);
      data_d  = WIDTH'(rs_c.data);
      sat_d   = rs_c.sat;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= eIDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         p_v_q   <= 1'b0;
         acc_q   <= '0;
         ready_q <= 1'b0;
         v_q     <= 1'b0;
         sat_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         p_v_q   <= p_v_d;
         acc_q   <= acc_d;
         ready_q <= ready_d;
         v_q     <= v_d;
         sat_q   <= sat_d;
         data_q  <= data_d;
      end
   end

   assign ready_o = ready_q;
   assign v_o     = v_q;
   assign sat_o   = sat_q;
   assign data_o  = data_q;

endmodule

// File: tb/tb_dot_product_vec.sv
// Scoreboard bench for dot_product_vec: one LANES=1 and one LANES=4 instance.
`timescale 1ns/1ps
module tb_dot_product_vec;

   localparam int unsigned LEN_W = 5;

   typedef struct {
      logic [15:0] data;
      logic        sat;
      int          cyc;
      int          hold;
   } exp_t;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b1;
   logic             start1 = 1'b0;
   logic             start4 = 1'b0;
   logic             v      = 1'b0;
   logic             yumi1  = 1'b0;
   logic             yumi4  = 1'b0;
   logic [LEN_W-1:0] len    = '0;
   logic [63:0]      a      = '0;
   logic [63:0]      b      = '0;
   logic             ready1, sat1, vo1, ready4, sat4, vo4;
   logic [15:0]      data1, data4;
   logic [63:0]      va [16];
   logic [63:0]      vb [16];
   exp_t             q1 [$];
   exp_t             q4 [$];
   int               cyc   = 0;
   int               n_chk = 0;
   int               n_err = 0;

   dot_product_vec #(.WIDTH(16), .FRAC(8), .LANES(1), .MAX_LEN(16)) u1 (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start1), .len_i(len),
      .a_i(a[15:0]), .b_i(b[15:0]), .v_i(v), .ready_o(ready1),
      .data_o(data1), .sat_o(sat1), .v_o(vo1), .yumi_i(yumi1));

   dot_product_vec #(.WIDTH(16), .FRAC(8), .LANES(4), .MAX_LEN(16)) u4 (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start4), .len_i(len),
      .a_i(a), .b_i(b), .v_i(v), .ready_o(ready4),
      .data_o(data4), .sat_o(sat4), .v_o(vo4), .yumi_i(yumi4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic vo_of(input int sel);
      return (sel == 1) ? vo1 : vo4;
   endfunction
   function automatic logic rdy_of(input int sel);
      return (sel == 1) ? ready1 : ready4;
   endfunction
   function automatic logic [15:0] data_of(input int sel);
      return (sel == 1) ? data1 : data4;
   endfunction
   function automatic logic sat_of(input int sel);
      return (sel == 1) ? sat1 : sat4;
   endfunction
   function automatic int qs(input int sel);
      return (sel == 1) ? q1.size() : q4.size();
   endfunction

   task automatic set_start(input int sel, input logic x);
      if (sel == 1) start1 = x; else start4 = x;
   endtask
   task automatic set_yumi(input int sel, input logic x);
      if (sel == 1) yumi1 = x; else yumi4 = x;
   endtask
   task automatic push(input int sel, input exp_t e);
      if (sel == 1) q1.push_back(e); else q4.push_back(e);
   endtask

   task automatic fill(input int n, input logic [63:0] av, input logic [63:0] bv);
      for (int i = 0; i < n; i++) begin
         va[i] = av;
         vb[i] = bv;
      end
   endtask

   // Monitor: pops the expected result whenever v_o rises, holds it, then acknowledges.
   task automatic mon(input int sel);
      exp_t        e;
      logic [15:0] d0;
      forever begin
         @(negedge clk);
         if (vo_of(sel) === 1'b1) begin
            if (qs(sel) == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_v_o dut%0d: v_o=1 with no expected result", sel);
            end else begin
               if (sel == 1) e = q1.pop_front(); else e = q4.pop_front();
               d0 = data_of(sel);
               check($sformatf("data_dut%0d", sel), 32'(d0), 32'(e.data));
               check($sformatf("sat_dut%0d", sel), 32'(sat_of(sel)), 32'(e.sat));
               check($sformatf("latency_dut%0d", sel), 32'(cyc), 32'(e.cyc));
               for (int h = 0; h < e.hold; h++) begin
                  @(negedge clk);
                  check($sformatf("hold_dut%0d", sel),
                        32'({vo_of(sel), rdy_of(sel), data_of(sel)}), 32'({1'b1, 1'b0, d0}));
               end
            end
            set_yumi(sel, 1'b1);
            @(negedge clk);
            set_yumi(sel, 1'b0);
         end
      end
   endtask

   initial mon(1);
   initial mon(4);

   // Driver: start a vector, stream n beats from va/vb, then wait for the result to be consumed.
   task automatic run_vec(input int sel, input int len_f, input int n,
                          input logic [15:0] ed, input logic es,
                          input bit gap, input int hold, input bit poke);
      exp_t e;
      int   i, t, pk;
      bit   ph;
      e.data = ed;
      e.sat  = es;
      e.hold = hold;
      e.cyc  = 0;
      @(negedge clk);
      len = LEN_W'(len_f);
      set_start(sel, 1'b1);
      if (n == 0) begin
         e.cyc = cyc + 1;
         push(sel, e);
      end
      i  = 0;
      t  = 0;
      ph = 1'b0;
      while (i < n && t < 200) begin
         @(negedge clk);
         set_start(sel, 1'b0);
         ph = ~ph;
         v  = gap ? ph : 1'b1;
         a  = va[i];
         b  = vb[i];
         if (v && rdy_of(sel)) begin
            if (i == n - 1) begin
               e.cyc = cyc + 2;
               push(sel, e);
            end
            i++;
         end
         t++;
      end
      check($sformatf("beats_taken_dut%0d", sel), 32'(i), 32'(n));
      @(negedge clk);
      v = 1'b0;
      set_start(sel, 1'b0);
      t  = 0;
      pk = 0;
      while ((qs(sel) != 0 || vo_of(sel) !== 1'b0) && t < 300) begin
         @(negedge clk);
         if (poke && vo_of(sel) && pk < 3) begin
            set_start(sel, 1'b1);
            pk++;
         end else begin
            set_start(sel, 1'b0);
         end
         t++;
      end
      set_start(sel, 1'b0);
      check($sformatf("result_consumed_dut%0d", sel), 32'(t < 300), 32'(1));
      if (t >= 300) begin
         if (sel == 1) q1.delete(); else q4.delete();
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_dut1", 32'({ready1, vo1, sat1, data1}), 32'(0));
      check("reset_dut4", 32'({ready4, vo4, sat4, data4}), 32'(0));
      rst_n = 1'b1;

      // 2.0 + 4.0 - 1.0 = 5.0
      va[0] = 64'h0100; vb[0] = 64'h0200;
      va[1] = 64'h0080; vb[1] = 64'h0800;
      va[2] = 64'hFF00; vb[2] = 64'h0100;
      run_vec(1, 3, 3, 16'h0500, 1'b0, 1'b0, 0, 1'b0);

      fill(4, 64'h7F00, 64'h7F00);
      run_vec(1, 4, 4, 16'h7FFF, 1'b1, 1'b0, 0, 1'b0);
      fill(4, 64'h7F00, 64'h8100);
      run_vec(1, 4, 4, 16'h8000, 1'b1, 1'b0, 0, 1'b0);

      // Backpressure: gapped beats, result held 5 cycles while start_i is pulsed.
      va[0] = 64'h0100; vb[0] = 64'h0200;
      va[1] = 64'h0080; vb[1] = 64'h0800;
      va[2] = 64'hFF00; vb[2] = 64'h0100;
      run_vec(1, 3, 3, 16'h0500, 1'b0, 1'b1, 5, 1'b1);

      // Rounding at exactly half an LSB, positive and negative.
      va[0] = 64'h0001; vb[0] = 64'h0080;
      run_vec(1, 1, 1, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      va[0] = 64'hFFFF; vb[0] = 64'h0080;
      run_vec(1, 1, 1, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
      // -1.5*3.0 + half LSB -> -4.5 rounded up to 0xFB81
      va[0] = 64'hFE80; vb[0] = 64'h0300;
      va[1] = 64'h0040; vb[1] = 64'h0002;
      run_vec(1, 2, 2, 16'hFB81, 1'b0, 1'b0, 0, 1'b0);

      // Reset after two of four beats.
      @(negedge clk);
      len    = LEN_W'(4);
      a      = 64'h0100;
      b      = 64'h0100;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      v      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      v      = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("reset_mid_vector", 32'({ready1, vo1, data1}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      va[0] = 64'h0100; vb[0] = 64'h0100;
      run_vec(1, 1, 1, 16'h0100, 1'b0, 1'b0, 0, 1'b0);

      run_vec(1, 0, 0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);

      // len_i above MAX_LEN is clamped to 16 beats.
      fill(16, 64'h0100, 64'h0100);
      run_vec(1, 31, 16, 16'h1000, 1'b0, 1'b0, 0, 1'b0);

      // Four lanes of 1.0*1.0 over two beats, then an empty vector.
      fill(2, {4{16'h0100}}, {4{16'h0100}});
      run_vec(4, 2, 2, 16'h0800, 1'b0, 1'b0, 0, 1'b0);
      run_vec(4, 0, 0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
